// File: rtl/camera_sensor_emu.sv
// DVP-style camera sensor emulator: divided pixel clock, vsync/href frame timing and pixel data
// sourced from an internal (row + col) pattern or an upstream valid/ready stream.
module camera_sensor_emu #(
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned PCLK_DIV  = 2,
  parameter int unsigned H_ACTIVE  = 320,
  parameter int unsigned H_BLANK   = 144,
  parameter int unsigned V_ACTIVE  = 240,
  parameter int unsigned VSYNC_LEN = 3,
  parameter int unsigned V_FRONT   = 16,
  parameter int unsigned V_POST    = 600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pattern_sel,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              pclk_out,
  output logic              vsync_out,
  output logic              href_out,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);

  localparam int unsigned DIV_W     = $clog2(PCLK_DIV);
  localparam int unsigned PCLK_HALF = PCLK_DIV / 2;
  localparam int unsigned MAX_A     = (VSYNC_LEN > V_FRONT) ? VSYNC_LEN : V_FRONT;
  localparam int unsigned MAX_B     = (H_BLANK > V_POST) ? H_BLANK : V_POST;
  localparam int unsigned CNT_MAX   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned COL_W     = $clog2(H_ACTIVE + 1);
  localparam int unsigned ROW_W     = $clog2(V_ACTIVE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VFRONT,
    S_ACTIVE,
    S_BLANK,
    S_VPOST
  } state_t;

  state_t              state_q, state_d, nxt_state;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, nxt_cnt;
  logic [COL_W-1:0]    col_q, col_d, nxt_col;
  logic [ROW_W-1:0]    row_q, row_d, nxt_row;
  logic                mode_q, mode_d, nxt_mode;
  logic                nxt_done;
  logic                tick_c;
  logic                pclk_q, pclk_d;
  logic                vsync_q, vsync_d;
  logic                href_q, href_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                underrun_q, underrun_d;
  logic                ready_q, ready_d;

  // State and output registers; everything resets to zero / IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      mode_q     <= 1'b0;
      pclk_q     <= 1'b0;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      mode_q     <= mode_d;
      pclk_q     <= pclk_d;
      vsync_q    <= vsync_d;
      href_q     <= href_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    tick_c = (div_q == DIV_W'(PCLK_DIV - 1));
    div_d  = tick_c ? '0 : div_q + DIV_W'(1);

    // Where the FSM goes on the next tick; state is constant between ticks
    nxt_state = state_q;
    nxt_cnt   = cnt_q + CNT_W'(1);
    nxt_col   = col_q;
    nxt_row   = row_q;
    nxt_mode  = mode_q;
    nxt_done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        nxt_cnt = '0;
        if (enable) begin
          nxt_state = S_VSYNC;
          nxt_row   = '0;
          nxt_col   = '0;
          nxt_mode  = pattern_sel;
        end
      end
      S_VSYNC: begin
        if (cnt_q == CNT_W'(VSYNC_LEN - 1)) begin
          nxt_state = S_VFRONT;
          nxt_cnt   = '0;
        end
      end
      S_VFRONT: begin
        if (cnt_q == CNT_W'(V_FRONT - 1)) begin
          nxt_state = S_ACTIVE;
          nxt_cnt   = '0;
          nxt_col   = '0;
        end
      end
      S_ACTIVE: begin
        nxt_cnt = '0;
        if (col_q == COL_W'(H_ACTIVE - 1)) begin
          if (row_q < ROW_W'(V_ACTIVE - 1)) begin
            nxt_state = S_BLANK;
            nxt_row   = row_q + ROW_W'(1);
          end else begin
            nxt_state = S_VPOST;
          end
        end else begin
          nxt_col = col_q + COL_W'(1);
        end
      end
      S_BLANK: begin
        if (cnt_q == CNT_W'(H_BLANK - 1)) begin
          nxt_state = S_ACTIVE;
          nxt_cnt   = '0;
          nxt_col   = '0;
        end
      end
      S_VPOST: begin
        if (cnt_q == CNT_W'(V_POST - 1)) begin
          nxt_done = 1'b1;
          nxt_cnt  = '0;
          if (enable) begin
            nxt_state = S_VSYNC;
            nxt_row   = '0;
            nxt_col   = '0;
            nxt_mode  = pattern_sel;
          end else begin
            nxt_state = S_IDLE;
          end
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    state_d    = state_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    mode_d     = mode_q;
    vsync_d    = vsync_q;
    href_d     = href_q;
    data_d     = data_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    if (tick_c) begin
      state_d = nxt_state;
      cnt_d   = nxt_cnt;
      col_d   = nxt_col;
      row_d   = nxt_row;
      mode_d  = nxt_mode;
      vsync_d = (nxt_state == S_VSYNC);
      href_d  = (nxt_state == S_ACTIVE);
      done_d  = nxt_done;
      data_d  = '0;
      if (nxt_state == S_ACTIVE) begin
        if (nxt_mode) begin
          data_d = DATA_W'(nxt_row) + DATA_W'(nxt_col);
        end else if (pix_valid) begin
          data_d = pix_data;
        end else begin
          underrun_d = 1'b1;
        end
      end
    end

    busy_d  = (state_d != S_IDLE);
    pclk_d  = (div_d >= DIV_W'(PCLK_HALF));
    // Ready covers exactly the clk cycle that ends in a pixel-loading tick
    ready_d = !mode_q && (nxt_state == S_ACTIVE) && (div_d == DIV_W'(PCLK_DIV - 1));
  end

  assign pix_ready  = ready_q;
  assign pclk_out   = pclk_q;
  assign vsync_out  = vsync_q;
  assign href_out   = href_q;
  assign data_out   = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign underrun   = underrun_q;

endmodule
